// File: rtl/strip_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | strip_control : keypad command sequencer for a multi-channel filter strip |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module strip_control #(
  parameter int NUM_CH       = 4,
  parameter int SEL_W        = 3,
  parameter int DEBOUNCE_CYC = 4800
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       kphit,
  input  logic [3:0]                 buttonNum,
  output logic [NUM_CH*SEL_W-1:0]    freq_sel,
  output logic [NUM_CH*SEL_W-1:0]    lp_sel,
  output logic [NUM_CH*SEL_W-1:0]    hp_sel,
  output logic [NUM_CH-1:0]          bypass,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic [1:0]                 field,
  output logic                       key_ack,
  output logic                       key_err
);

  localparam int                CH_W      = $clog2(NUM_CH);
  localparam int                CNT_W     = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [4:0]        SEL_LIMIT = 5'(2 ** SEL_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    EXEC    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        code_q;

  logic              kphit_meta;
  logic              kphit_s;
  logic [3:0]        code_meta;
  logic [3:0]        code_s;

  logic [SEL_W-1:0]  freq_r [NUM_CH];
  logic [SEL_W-1:0]  lp_r   [NUM_CH];
  logic [SEL_W-1:0]  hp_r   [NUM_CH];

  // Keypad lines are asynchronous to clk; each bit gets its own 2-flop chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kphit_meta <= 1'b0;
      kphit_s    <= 1'b0;
      code_meta  <= 4'd0;
      code_s     <= 4'd0;
    end else begin
      kphit_meta <= kphit;
      kphit_s    <= kphit_meta;
      code_meta  <= buttonNum;
      code_s     <= code_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RELEASE;
      cnt       <= '0;
      code_q    <= 4'd0;
      bypass    <= '0;
      active_ch <= '0;
      field     <= 2'd0;
      key_ack   <= 1'b0;
      key_err   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        freq_r[i] <= '0;
        lp_r[i]   <= '0;
        hp_r[i]   <= '0;
      end
    end else begin
      key_ack <= 1'b0;
      key_err <= 1'b0;
      case (state)
        IDLE: begin
          if (kphit_s) begin
            code_q <= code_s;
            cnt    <= CNT_W'(1);
            state  <= PRESS;
          end
        end

        PRESS: begin
          if (kphit_s && (code_s == code_q)) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= EXEC;
            end
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end

        EXEC: begin
          cnt   <= '0;
          state <= RELEASE;
          if (code_q <= 4'd9) begin
            if ({1'b0, code_q} < SEL_LIMIT) begin
              case (field)
                2'd0:    freq_r[active_ch] <= code_q[SEL_W-1:0];
                2'd1:    lp_r[active_ch]   <= code_q[SEL_W-1:0];
                default: hp_r[active_ch]   <= code_q[SEL_W-1:0];
              endcase
              key_ack <= 1'b1;
            end else begin
              key_err <= 1'b1;
            end
          end else begin
            key_ack <= 1'b1;
            case (code_q)
              4'hA: field <= 2'd0;
              4'hB: field <= 2'd1;
              4'hC: field <= 2'd2;
              4'hD: active_ch <= (active_ch == CH_LAST) ? '0 : active_ch + 1'b1;
              4'hE: bypass[active_ch] <= ~bypass[active_ch];
              default: begin
                freq_r[active_ch] <= '0;
                lp_r[active_ch]   <= '0;
                hp_r[active_ch]   <= '0;
                bypass[active_ch] <= 1'b0;
              end
            endcase
          end
        end

        RELEASE: begin
          // A key still held (including one held through reset) re-arms nothing.
          if (kphit_s) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= RELEASE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign freq_sel[g*SEL_W +: SEL_W] = freq_r[g];
    assign lp_sel[g*SEL_W +: SEL_W]   = lp_r[g];
    assign hp_sel[g*SEL_W +: SEL_W]   = hp_r[g];
  end

endmodule
`default_nettype wire
